cmat_operand_packer: RTL and testbench

CMAT_OPERAND_PACKER -- requirements
Module: cmat_operand_packer

---
 rtl/cmat_operand_packer_pkg.sv | 15 +
 rtl/cmat_packer_bank.sv | 67 ++++++
 rtl/cmat_operand_packer.sv | 94 +++++++++
 tb/tb_cmat_operand_packer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmat_operand_packer_pkg.sv
// Shared types for the complex-matrix operand packer: default vector size,
// the 4x64 input beat and the per-bank state encoding.
package cmat_operand_packer_pkg;

  localparam int CMAT_SIZE_DEFAULT = 16;

  // {b2, a2, b1, a1}: word 0 is a1
  typedef logic [3:0][63:0] beat_t;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } bank_state_e;

endpackage

// File: rtl/cmat_packer_bank.sv
// One operand bank: lane storage, beat counter and FILL/SEND state machine.
//   state | meaning
//   FILL  | accepting beats into lane cnt; unwritten lanes stay zero
//   SEND  | vector closed, presented downstream until handshake
module cmat_packer_bank
  import cmat_operand_packer_pkg::*;
#(
  parameter int SIZE = CMAT_SIZE_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          wr_en,
  input  beat_t                         beat,
  input  logic                          last,
  input  logic                          ack,
  output bank_state_e                   state,
  output logic [SIZE*4-1:0][63:0]       operands,
  output logic [$clog2(SIZE+1)-1:0]     count
);

  localparam int CW = $clog2(SIZE + 1);
  localparam int IW = $clog2(SIZE);

  bank_state_e                state_q, state_d;
  logic [CW-1:0]              cnt_q;
  logic [SIZE-1:0][3:0][63:0] lanes_q;
  logic                       closing;

  assign closing = wr_en && (last || cnt_q == CW'(SIZE - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: if (closing) state_d = SEND;
      SEND: if (ack)     state_d = FILL;
      default:           state_d = FILL;
    endcase
    if (flush) state_d = FILL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      // flush wins over any beat or handshake in the same cycle
      if (flush) begin
        cnt_q   <= '0;
        lanes_q <= '0;
      end else if (state_q == FILL && wr_en) begin
        lanes_q[cnt_q[IW-1:0]] <= beat;
        cnt_q                  <= cnt_q + CW'(1);
      end else if (state_q == SEND && ack) begin
        cnt_q   <= '0;
        lanes_q <= '0;
      end
    end
  end

  assign state    = state_q;
  assign operands = lanes_q;
  assign count    = cnt_q;

endmodule

// File: rtl/cmat_operand_packer.sv
// Packs 4x64 operand beats into SIZE-lane vectors for the complex dot-product engine.
// Define CMAT_PACKER_PINGPONG_EN for two alternating banks; default is a single bank.
module cmat_operand_packer
  import cmat_operand_packer_pkg::*;
#(
  parameter int SIZE = CMAT_SIZE_DEFAULT
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  beat_t                         s_operands_i,
  input  logic                          s_valid_i,
  input  logic                          s_last_i,
  output logic                          s_ready_o,
  output logic [SIZE*4-1:0][63:0]       operands_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [$clog2(SIZE+1)-1:0]     count_o,
  input  logic                          flush_i,
  output logic                          busy_o
);

  localparam int CW = $clog2(SIZE + 1);

`ifdef CMAT_PACKER_PINGPONG_EN

  bank_state_e               bank_state [2];
  logic [SIZE*4-1:0][63:0]   bank_ops   [2];
  logic [CW-1:0]             bank_cnt   [2];
  logic                      wr_ptr, rd_ptr;
  logic                      accept, close, handshake;

  assign accept    = s_valid_i && s_ready_o;
  assign close     = accept && (s_last_i || bank_cnt[wr_ptr] == CW'(SIZE - 1));
  assign handshake = out_valid_o && out_ready_i;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    cmat_packer_bank #(.SIZE(SIZE)) u_bank (
      .clk      (clk_i),
      .rst      (rst_i),
      .flush    (flush_i),
      .wr_en    (accept && (wr_ptr == 1'(g))),
      .beat     (s_operands_i),
      .last     (s_last_i),
      .ack      (handshake && (rd_ptr == 1'(g))),
      .state    (bank_state[g]),
      .operands (bank_ops[g]),
      .count    (bank_cnt[g])
    );
  end

  // Banks close and drain in the same order, so two toggling pointers keep vector order
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (close)     wr_ptr <= ~wr_ptr;
      if (handshake) rd_ptr <= ~rd_ptr;
    end
  end

  assign s_ready_o   = (bank_state[wr_ptr] == FILL);
  assign out_valid_o = (bank_state[rd_ptr] == SEND);
  assign operands_o  = bank_ops[rd_ptr];
  assign count_o     = bank_cnt[rd_ptr];
  assign busy_o      = (bank_cnt[0] != '0) || (bank_cnt[1] != '0) || out_valid_o;

`else

  bank_state_e bank_state;

  cmat_packer_bank #(.SIZE(SIZE)) u_bank (
    .clk      (clk_i),
    .rst      (rst_i),
    .flush    (flush_i),
    .wr_en    (s_valid_i && s_ready_o),
    .beat     (s_operands_i),
    .last     (s_last_i),
    .ack      (out_valid_o && out_ready_i),
    .state    (bank_state),
    .operands (operands_o),
    .count    (count_o)
  );

  assign s_ready_o   = (bank_state == FILL);
  assign out_valid_o = (bank_state == SEND);
  assign busy_o      = (count_o != '0) || out_valid_o;

`endif

endmodule

// File: tb/tb_cmat_operand_packer.sv
// Scoreboard bench for cmat_operand_packer; expected vectors are queued on beat acceptance.
module tb_cmat_operand_packer;
  import cmat_operand_packer_pkg::*;

  localparam int SIZE = 16;
  localparam int CW   = $clog2(SIZE + 1);

  typedef struct packed {
    logic [SIZE*4-1:0][63:0] ops;
    logic [CW-1:0]           cnt;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  beat_t                   s_operands = '0;
  logic                    s_valid = 1'b0;
  logic                    s_last = 1'b0;
  logic                    s_ready;
  logic [SIZE*4-1:0][63:0] operands;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [CW-1:0]           count;
  logic                    flush = 1'b0;
  logic                    busy;

  exp_t                    q[$];
  logic [SIZE*4-1:0][63:0] m_ops = '0;
  int                      m_cnt = 0;
  int                      pushes = 0;
  int                      total = 0;
  int                      bad = 0;
  logic                    acc;

  cmat_operand_packer #(.SIZE(SIZE)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .s_operands_i (s_operands),
    .s_valid_i    (s_valid),
    .s_last_i     (s_last),
    .s_ready_o    (s_ready),
    .operands_o   (operands),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .count_o      (count),
    .flush_i      (flush),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int base);
    beat_t b;
    for (int i = 0; i < 4; i++) b[i] = 64'(base + i);
    return b;
  endfunction

  task automatic model_clear();
    m_ops = '0;
    m_cnt = 0;
    q.delete();
  endtask

  task automatic model_accept(input beat_t b, input logic l);
    exp_t e;
    for (int i = 0; i < 4; i++) m_ops[m_cnt*4 + i] = b[i];
    m_cnt++;
    if (l || m_cnt == SIZE) begin
      e.ops = m_ops;
      e.cnt = CW'(m_cnt);
      q.push_back(e);
      pushes++;
      m_ops = '0;
      m_cnt = 0;
    end
  endtask

  // Drive at the falling edge, then score the handshakes the next rising edge will perform
  task automatic cyc(input logic v, input beat_t b, input logic l, input logic rdy, input logic fl);
    exp_t e;
    @(negedge clk);
    s_valid    = v;
    s_operands = b;
    s_last     = l;
    out_ready  = rdy;
    flush      = fl;
    #1;
    acc = v && s_ready && !fl;
    if (fl) begin
      model_clear();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_vec", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("sb_count", 64'(count), 64'(e.cnt));
          for (int w = 0; w < SIZE*4; w++) check("sb_word", operands[w], e.ops[w]);
        end
      end
      if (acc) model_accept(b, l);
    end
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, '0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    beat_t b;
    int    start, n;
    logic  v, l, rdy;

    // reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ops", 64'(operands != '0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1);
    check("rst_ready", 64'(s_ready), 64'd1);

    // full 16-beat vector, words 1..64
    for (int j = 0; j < SIZE; j++) begin
      cyc(1'b1, mk_beat(4*j + 1), 1'b0, 1'b1, 1'b0);
      check("t28_acc", 64'(acc), 64'd1);
      check("t28_pre", 64'(out_valid), 64'd0);
    end
    idle(1'b1);
    check("t28_valid", 64'(out_valid), 64'd1);
    check("t28_count", 64'(count), 64'd16);
    for (int w = 0; w < SIZE*4; w++) check("t28_word", operands[w], 64'(w + 1));

    // short vector closed by s_last
    for (int j = 0; j < 3; j++) cyc(1'b1, mk_beat(100 + 4*j), (j == 2), 1'b1, 1'b0);
    idle(1'b1);
    check("t29_valid", 64'(out_valid), 64'd1);
    check("t29_count", 64'(count), 64'd3);
    for (int w = 0; w < 12; w++) check("t29_word", operands[w], 64'(100 + w));
    for (int w = 12; w < SIZE*4; w++) check("t29_zero", operands[w], 64'd0);

    // back-pressure hold
    for (int j = 0; j < SIZE; j++) cyc(1'b1, mk_beat(1000 + 4*j), 1'b0, 1'b0, 1'b0);
`ifdef CMAT_PACKER_PINGPONG_EN
    for (int j = 0; j < SIZE; j++) begin
      cyc(1'b1, mk_beat(2000 + 4*j), 1'b0, 1'b0, 1'b0);
      check("t30_pp_acc", 64'(acc), 64'd1);
      check("t30_valid", 64'(out_valid), 64'd1);
      for (int w = 0; w < SIZE*4; w++) check("t30_hold", operands[w], 64'(1000 + w));
    end
    idle(1'b0);
    check("t30_pp_full", 64'(s_ready), 64'd0);
    check("t30_hold_cnt", 64'(count), 64'd16);
`else
    for (int k = 0; k < 5; k++) begin
      idle(1'b0);
      check("t30_valid", 64'(out_valid), 64'd1);
      check("t30_ready", 64'(s_ready), 64'd0);
      check("t30_hold_cnt", 64'(count), 64'd16);
      for (int w = 0; w < SIZE*4; w++) check("t30_hold", operands[w], 64'(1000 + w));
    end
`endif
    for (int k = 0; k < 4; k++) idle(1'b1);
    check("t30_drain", 64'(q.size()), 64'd0);
    check("t30_idle", 64'(out_valid), 64'd0);

    // flush on beat 7
    for (int j = 0; j < 6; j++) cyc(1'b1, mk_beat(3000 + 4*j), 1'b0, 1'b1, 1'b0);
    check("t31_busy_pre", 64'(busy), 64'd1);
    cyc(1'b1, mk_beat(3024), 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    check("t31_busy", 64'(busy), 64'd0);
    check("t31_valid", 64'(out_valid), 64'd0);
    check("t31_ready", 64'(s_ready), 64'd1);
    for (int j = 0; j < SIZE; j++) cyc(1'b1, mk_beat(4000 + 4*j), 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    check("t31_lane0", operands[0], 64'd4000);
    check("t31_count", 64'(count), 64'd16);

    // asynchronous reset while presenting
    for (int j = 0; j < SIZE; j++) cyc(1'b1, mk_beat(5000 + 4*j), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("t32_valid_pre", 64'(out_valid), 64'd1);
    s_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t32_valid_rst", 64'(out_valid), 64'd0);
    check("t32_busy_rst", 64'(busy), 64'd0);
    check("t32_count_rst", 64'(count), 64'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1);
    check("t32_ready", 64'(s_ready), 64'd1);
    for (int j = 0; j < SIZE; j++) cyc(1'b1, mk_beat(6000 + 4*j), 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    check("t32_count", 64'(count), 64'd16);
    check("t32_word63", operands[63], 64'd6063);

    // random back-pressure, 1000 vectors
    start = pushes;
    n = 0;
    while (pushes - start < 1000 && n < 60000) begin
      for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom};
      v   = ($urandom_range(0, 9) < 7);
      l   = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      cyc(v, b, l, rdy, 1'b0);
      n++;
    end
    check("t33_vectors", 64'(pushes - start >= 1000), 64'd1);
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      cyc(1'b1, mk_beat(7000), 1'b1, 1'b1, 1'b0);
      n++;
    end
    check("t33_close", 64'(acc), 64'd1);
    n = 0;
    while (q.size() != 0 && n < 100) begin
      idle(1'b1);
      n++;
    end
    check("t33_drain", 64'(q.size()), 64'd0);
    idle(1'b1);
    check("t33_final_valid", 64'(out_valid), 64'd0);
    check("t33_final_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
